// File: rtl/branch_resolve_queue_if.sv
// Handshake and status bundle between the branch predictor front end and the resolve queue.
// The queue takes the slave side; the issuing/resolving logic takes the master side.
interface branch_resolve_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic             pred_taken;
    logic             alloc_ready;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             resolve_ready;
    logic             upd_valid;
    logic             upd_taken;
    logic             mispredict;
    logic             underflow;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output pred_valid, pred_taken, resolve_valid, resolve_taken,
        input  alloc_ready, resolve_ready, upd_valid, upd_taken,
               mispredict, underflow, occupancy, hit_count, miss_count
    );

    modport slave (
        input  pred_valid, pred_taken, resolve_valid, resolve_taken,
        output alloc_ready, resolve_ready, upd_valid, upd_taken,
               mispredict, underflow, occupancy, hit_count, miss_count
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions: matches each against its resolved outcome,
// drives the predictor update, squashes younger entries on a mispredict and keeps hit/miss stats.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_resolve_queue_if.slave   brq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] head, head_n;
    logic [PTR_W-1:0] tail, tail_n;
    logic [OCC_W-1:0] occ, occ_n;
    logic             upd_valid, upd_valid_n;
    logic             upd_taken, upd_taken_n;
    logic             mispredict, mispredict_n;
    logic             underflow, underflow_n;
    logic [CNT_W-1:0] hit_cnt, hit_cnt_n;
    logic [CNT_W-1:0] miss_cnt, miss_cnt_n;

    // Stored predicted directions; contents are don't-care after reset.
    logic [DEPTH-1:0] ent;

    logic alloc_ready_c;
    logic resolve_ready_c;
    logic do_alloc_c;
    logic do_res_c;
    logic miss_c;

    assign alloc_ready_c   = (occ != OCC_W'(DEPTH));
    assign resolve_ready_c = (occ != '0);
    assign do_alloc_c      = brq.pred_valid && alloc_ready_c;
    assign do_res_c        = brq.resolve_valid && resolve_ready_c;
    assign miss_c          = do_res_c && (ent[head] != brq.resolve_taken);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            upd_valid  <= 1'b0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
            underflow  <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            head       <= head_n;
            tail       <= tail_n;
            occ        <= occ_n;
            upd_valid  <= upd_valid_n;
            upd_taken  <= upd_taken_n;
            mispredict <= mispredict_n;
            underflow  <= underflow_n;
            hit_cnt    <= hit_cnt_n;
            miss_cnt   <= miss_cnt_n;
        end
    end

    // Entry storage needs no reset; a squashed write lands outside the live window.
    always_ff @(posedge clk) begin
        if (do_alloc_c) begin
            ent[tail] <= brq.pred_taken;
        end
    end

    // Next-state: pointer/occupancy bookkeeping, resolve strobes and saturating counters.
    always_comb begin
        head_n       = head;
        tail_n       = tail;
        occ_n        = occ;
        upd_valid_n  = 1'b0;
        upd_taken_n  = upd_taken;
        mispredict_n = 1'b0;
        underflow_n  = 1'b0;
        hit_cnt_n    = hit_cnt;
        miss_cnt_n   = miss_cnt;

        if (do_alloc_c) begin
            tail_n = tail + PTR_W'(1);
        end

        if (do_res_c) begin
            head_n      = head + PTR_W'(1);
            upd_valid_n = 1'b1;
            upd_taken_n = brq.resolve_taken;
        end

        occ_n = occ + OCC_W'(do_alloc_c) - OCC_W'(do_res_c);

        if (miss_c) begin
            // Everything younger, including a same-cycle allocation, is flushed.
            mispredict_n = 1'b1;
            tail_n       = head + PTR_W'(1);
            occ_n        = '0;
            if (miss_cnt != {CNT_W{1'b1}}) begin
                miss_cnt_n = miss_cnt + CNT_W'(1);
            end
        end else if (do_res_c) begin
            if (hit_cnt != {CNT_W{1'b1}}) begin
                hit_cnt_n = hit_cnt + CNT_W'(1);
            end
        end

        if (brq.resolve_valid && !resolve_ready_c) begin
            underflow_n = 1'b1;
        end
    end

    assign brq.alloc_ready   = alloc_ready_c;
    assign brq.resolve_ready = resolve_ready_c;
    assign brq.upd_valid     = upd_valid;
    assign brq.upd_taken     = upd_taken;
    assign brq.mispredict    = mispredict;
    assign brq.underflow     = underflow;
    assign brq.occupancy     = occ;
    assign brq.hit_count     = hit_cnt;
    assign brq.miss_count    = miss_cnt;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (DEPTH=4, CNT_W=2) with hand-computed expectations.
module tb_branch_resolve_queue;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   mq[$];

    branch_resolve_queue_if #(.DEPTH(4), .CNT_W(2)) bus ();

    branch_resolve_queue #(.DEPTH(4), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .brq (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample on the following falling edge.
    task automatic cyc(input logic pv, input logic pt, input logic rv, input logic rt);
        bus.pred_valid    = pv;
        bus.pred_taken    = pt;
        bus.resolve_valid = rv;
        bus.resolve_taken = rt;
        @(posedge clk);
        @(negedge clk);
        bus.pred_valid    = 1'b0;
        bus.resolve_valid = 1'b0;
    endtask

    task automatic check_all(input string tag, input int occ, input logic ar, input logic rr,
                             input logic uv, input logic mp, input logic uf,
                             input int hit, input int miss);
        check({tag, ".occ"},   32'(bus.occupancy),     32'(occ));
        check({tag, ".ar"},    32'(bus.alloc_ready),   32'(ar));
        check({tag, ".rr"},    32'(bus.resolve_ready), 32'(rr));
        check({tag, ".uv"},    32'(bus.upd_valid),     32'(uv));
        check({tag, ".mp"},    32'(bus.mispredict),    32'(mp));
        check({tag, ".uf"},    32'(bus.underflow),     32'(uf));
        check({tag, ".hit"},   32'(bus.hit_count),     32'(hit));
        check({tag, ".miss"},  32'(bus.miss_count),    32'(miss));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.pred_valid    = 1'b0;
        bus.pred_taken    = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_taken = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all("reset", 0, 1, 0, 0, 0, 0, 0, 0);
        check("reset.ut", 32'(bus.upd_taken), 32'(0));

        // Allocate 1,0,1.
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check_all("alloc3", 3, 1, 1, 0, 0, 0, 0, 0);

        // Correct resolve of head (1).
        cyc(0, 0, 1, 1);
        check_all("hit1", 2, 1, 1, 1, 0, 0, 1, 0);
        check("hit1.ut", 32'(bus.upd_taken), 32'(1));

        // Idle: strobe drops, upd_taken holds.
        cyc(0, 0, 0, 0);
        check_all("idle", 2, 1, 1, 0, 0, 0, 1, 0);
        check("idle.ut", 32'(bus.upd_taken), 32'(1));

        // Correct resolve of 0 with simultaneous allocation of 1: queue [1,1].
        cyc(1, 1, 1, 0);
        check_all("allocres", 2, 1, 1, 1, 0, 0, 2, 0);
        check("allocres.ut", 32'(bus.upd_taken), 32'(0));

        // Fill to [1,1,0,1].
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check_all("full", 4, 0, 1, 0, 0, 0, 2, 0);

        // Allocation while full is dropped.
        cyc(1, 0, 0, 0);
        check_all("drop", 4, 0, 1, 0, 0, 0, 2, 0);

        // Full: correct resolve with allocation; allocation still rejected -> [1,0,1].
        cyc(1, 0, 1, 1);
        check_all("fullres", 3, 1, 1, 1, 0, 0, 3, 0);

        // Mispredict on head (1 vs 0) with simultaneous allocation: full squash.
        cyc(1, 1, 1, 0);
        check_all("squash", 0, 1, 0, 1, 1, 0, 3, 1);
        check("squash.ut", 32'(bus.upd_taken), 32'(0));

        // Resolve on empty with allocation: underflow, allocation kept.
        cyc(1, 1, 1, 1);
        check_all("underflow", 1, 1, 1, 0, 0, 1, 3, 1);
        mq.push_back(1'b1);

        // Alternate allocate/resolve across the pointer wrap; hit count stays saturated.
        for (int i = 0; i < 5; i++) begin
            logic v;
            bit   h;
            v = logic'((32'h16 >> i) & 32'h1);
            cyc(1, v, 0, 0);
            mq.push_back(v);
            check("alt.alloc.occ", 32'(bus.occupancy), 32'(mq.size()));
            h = mq.pop_front();
            cyc(0, 0, 1, h);
            check("alt.res.uv", 32'(bus.upd_valid), 32'(1));
            check("alt.res.ut", 32'(bus.upd_taken), 32'(h));
            check("alt.res.mp", 32'(bus.mispredict), 32'(0));
            check("alt.res.occ", 32'(bus.occupancy), 32'(mq.size()));
            check("alt.res.hit", 32'(bus.hit_count), 32'(3));
        end

        // Build occupancy 3 with a live update strobe, then reset mid-cycle.
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, mq[0]);
        check_all("prerst", 3, 1, 1, 1, 0, 0, 3, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all("asyncrst", 0, 1, 0, 0, 0, 0, 0, 0);
        check("asyncrst.ut", 32'(bus.upd_taken), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 1, 0);
        check_all("postrst", 0, 1, 0, 0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
